dac_channel_scheduler: RTL and testbench

Sequences and shares the single 24-bit DAC SPI serializer between the two audio output channels (A = left, B = right). Converts signed samples from the sample generator into DAC8562-format command words and, optionally, issues the DAC power-up initialisation sequence after reset. Sits between the additive-synthesis output stage and the SPI serializer, driving the serializer's data/send inputs and watching its ready output.

---
 rtl/dac_sched_pkg.sv | 37 +++
 rtl/dac_sample_slot.sv | 36 +++
 rtl/dac_channel_scheduler.sv | 129 ++++++++++++
 tb/tb_dac_channel_scheduler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg: shared states, DAC8562 command constants and init words for the DAC scheduler
// Contents: state_t, CMD_*/ADDR_* constants, INIT_WORDS/INIT_COUNT, dac_word/to_offset helpers,
// and the reset state / reset init-done value selected by the DAC_INIT_SEQ_EN macro.
package dac_sched_pkg;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND, ST_WAIT} state_t;

    localparam logic [2:0] CMD_WRITE_UPDATE = 3'b011;
    localparam logic [2:0] CMD_RESET        = 3'b101;
    localparam logic [2:0] CMD_REF          = 3'b111;
    localparam logic [2:0] ADDR_A           = 3'b000;
    localparam logic [2:0] ADDR_B           = 3'b001;

    localparam int INIT_COUNT = 2;
    localparam logic [23:0] INIT_WORDS [INIT_COUNT] = '{
        {2'b00, CMD_RESET, ADDR_A, 16'h0001},
        {2'b00, CMD_REF,   ADDR_A, 16'h0001}
    };

    function automatic logic [23:0] dac_word(input logic [2:0] cmd, input logic [2:0] addr, input logic [15:0] data);
        return {2'b00, cmd, addr, data};
    endfunction

    // Signed two's complement to the DAC's offset-binary code.
    function automatic logic [15:0] to_offset(input logic [15:0] s);
        return {~s[15], s[14:0]};
    endfunction

`ifdef DAC_INIT_SEQ_EN
    localparam state_t ST_RESET        = ST_INIT;
    localparam logic   INIT_DONE_RESET = 1'b0;
`else
    localparam state_t ST_RESET        = ST_IDLE;
    localparam logic   INIT_DONE_RESET = 1'b1;
`endif

endpackage

// File: rtl/dac_sample_slot.sv
// dac_sample_slot: one-entry sample holding register with pending flag and overrun detection
// Ports: i_Clock, i_Reset_N (sync active-low), i_Sample/i_Valid (load strobe),
// i_Consume (scheduler takes the slot this cycle), o_Sample, o_Pending, o_Overrun (one-cycle pulse).
module dac_sample_slot (
    input  logic        i_Clock,
    input  logic        i_Reset_N,
    input  logic [15:0] i_Sample,
    input  logic        i_Valid,
    input  logic        i_Consume,
    output logic [15:0] o_Sample,
    output logic        o_Pending,
    output logic        o_Overrun
);

    logic [15:0] r_Sample;
    logic        r_Pending;
    logic        r_Overrun;

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_Sample  <= '0;
            r_Pending <= 1'b0;
            r_Overrun <= 1'b0;
        end else begin
            if (i_Valid) r_Sample <= i_Sample;
            // A load in the consume cycle keeps the slot pending for the new value.
            r_Pending <= i_Valid | (r_Pending & ~i_Consume);
            r_Overrun <= i_Valid & r_Pending & ~i_Consume;
        end
    end

    assign o_Sample  = r_Sample;
    assign o_Pending = r_Pending;
    assign o_Overrun = r_Overrun;

endmodule

// File: rtl/dac_channel_scheduler.sv
// dac_channel_scheduler: shares one 24-bit DAC SPI serializer between audio channels A and B
// Ports: i_Clock, i_Reset_N (sync active-low), i_Sample_A/i_Valid_A, i_Sample_B/i_Valid_B,
// o_DAC_Data/o_DAC_Send/i_DAC_Ready (serializer handshake), o_Overrun, o_Init_Done.
// Build option: DAC_INIT_SEQ_EN enables the post-reset DAC init word sequence.
module dac_channel_scheduler
    import dac_sched_pkg::*;
(
    input  logic        i_Clock,
    input  logic        i_Reset_N,
    input  logic [15:0] i_Sample_A,
    input  logic        i_Valid_A,
    input  logic [15:0] i_Sample_B,
    input  logic        i_Valid_B,
    output logic [23:0] o_DAC_Data,
    output logic        o_DAC_Send,
    input  logic        i_DAC_Ready,
    output logic        o_Overrun,
    output logic        o_Init_Done
);

    state_t      r_State, w_State_Next;
    logic [23:0] r_Data, w_Data_Next;
    logic        r_Send, w_Send_Next;
    logic        r_Last_B, w_Last_B_Next;
    logic        r_Init_Done, w_Init_Done_Next;
    logic        r_Init_Idx, w_Init_Idx_Next;
    logic        w_Consume_A, w_Consume_B, w_Pick_A;
    logic [15:0] w_Slot_A, w_Slot_B;
    logic        w_Pending_A, w_Pending_B, w_Overrun_A, w_Overrun_B;

    dac_sample_slot u_slot_a (
        .i_Clock   (i_Clock),
        .i_Reset_N (i_Reset_N),
        .i_Sample  (i_Sample_A),
        .i_Valid   (i_Valid_A),
        .i_Consume (w_Consume_A),
        .o_Sample  (w_Slot_A),
        .o_Pending (w_Pending_A),
        .o_Overrun (w_Overrun_A)
    );

    dac_sample_slot u_slot_b (
        .i_Clock   (i_Clock),
        .i_Reset_N (i_Reset_N),
        .i_Sample  (i_Sample_B),
        .i_Valid   (i_Valid_B),
        .i_Consume (w_Consume_B),
        .o_Sample  (w_Slot_B),
        .o_Pending (w_Pending_B),
        .o_Overrun (w_Overrun_B)
    );

    // Round-robin: A wins a tie only when B was served last.
    assign w_Pick_A = w_Pending_A & (~w_Pending_B | r_Last_B);

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_N) begin
            r_State     <= ST_RESET;
            r_Data      <= '0;
            r_Send      <= 1'b0;
            r_Last_B    <= 1'b1;
            r_Init_Done <= INIT_DONE_RESET;
            r_Init_Idx  <= 1'b0;
        end else begin
            r_State     <= w_State_Next;
            r_Data      <= w_Data_Next;
            r_Send      <= w_Send_Next;
            r_Last_B    <= w_Last_B_Next;
            r_Init_Done <= w_Init_Done_Next;
            r_Init_Idx  <= w_Init_Idx_Next;
        end
    end

    always_comb begin
        w_State_Next     = r_State;
        w_Data_Next      = r_Data;
        w_Send_Next      = r_Send;
        w_Last_B_Next    = r_Last_B;
        w_Init_Done_Next = r_Init_Done;
        w_Init_Idx_Next  = r_Init_Idx;
        w_Consume_A      = 1'b0;
        w_Consume_B      = 1'b0;
        case (r_State)
            ST_INIT: begin
                if (i_DAC_Ready) begin
                    w_Data_Next  = INIT_WORDS[r_Init_Idx];
                    w_Send_Next  = 1'b1;
                    w_State_Next = ST_SEND;
                end
            end
            ST_IDLE: begin
                if (i_DAC_Ready && (w_Pending_A || w_Pending_B)) begin
                    w_Data_Next   = w_Pick_A ? dac_word(CMD_WRITE_UPDATE, ADDR_A, to_offset(w_Slot_A))
                                             : dac_word(CMD_WRITE_UPDATE, ADDR_B, to_offset(w_Slot_B));
                    w_Consume_A   = w_Pick_A;
                    w_Consume_B   = ~w_Pick_A;
                    w_Last_B_Next = ~w_Pick_A;
                    w_Send_Next   = 1'b1;
                    w_State_Next  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!i_DAC_Ready) begin
                    w_Send_Next  = 1'b0;
                    w_State_Next = ST_WAIT;
                end
            end
            default: begin
                if (i_DAC_Ready) begin
                    if (r_Init_Done) begin
                        w_State_Next = ST_IDLE;
                    end else if (r_Init_Idx == 1'(INIT_COUNT - 1)) begin
                        w_Init_Done_Next = 1'b1;
                        w_State_Next     = ST_IDLE;
                    end else begin
                        w_Init_Idx_Next = r_Init_Idx + 1'b1;
                        w_State_Next    = ST_INIT;
                    end
                end
            end
        endcase
    end

    assign o_DAC_Data  = r_Data;
    assign o_DAC_Send  = r_Send;
    assign o_Overrun   = w_Overrun_A | w_Overrun_B;
    assign o_Init_Done = r_Init_Done;

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// tb_dac_channel_scheduler: directed self-checking bench with a behavioural serializer model
module tb_dac_channel_scheduler;

`ifdef DAC_INIT_SEQ_EN
    localparam int N_INIT = 2;
`else
    localparam int N_INIT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample_a = '0;
    logic        valid_a = 1'b0;
    logic [15:0] sample_b = '0;
    logic        valid_b = 1'b0;
    logic [23:0] o_DAC_Data;
    logic        o_DAC_Send;
    logic        o_Overrun;
    logic        o_Init_Done;
    logic        w_ready;

    int n_checks = 0;
    int n_err = 0;

    dac_channel_scheduler dut (
        .i_Clock     (clk),
        .i_Reset_N   (rst_n),
        .i_Sample_A  (sample_a),
        .i_Valid_A   (valid_a),
        .i_Sample_B  (sample_b),
        .i_Valid_B   (valid_b),
        .o_DAC_Data  (o_DAC_Data),
        .o_DAC_Send  (o_DAC_Send),
        .i_DAC_Ready (w_ready),
        .o_Overrun   (o_Overrun),
        .o_Init_Done (o_Init_Done)
    );

    always #5 clk = ~clk;

    // Serializer model: acts on alternate clocks, busy for 20 cycles per word.
    logic        r_busy = 1'b0;
    logic        r_ph = 1'b0;
    int          r_cnt = 0;
    logic        r_prev_send = 1'b0;
    logic [23:0] r_prev_data = '0;
    logic [23:0] q_log[$];
    int          early_cnt = 0;
    int          unstable_cnt = 0;
    int          ovr_cnt = 0;

    assign w_ready = !r_busy;

    always @(posedge clk) begin
        r_prev_send <= o_DAC_Send;
        r_prev_data <= o_DAC_Data;
        r_ph <= !r_ph;
        if (o_Overrun) ovr_cnt <= ovr_cnt + 1;
        if (o_DAC_Send && r_prev_send && o_DAC_Data != r_prev_data) unstable_cnt <= unstable_cnt + 1;
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_cnt <= 0;
        end else if (!r_busy && r_ph && o_DAC_Send) begin
            r_busy <= 1'b1;
            r_cnt <= 20;
            q_log.push_back(o_DAC_Data);
            if (o_DAC_Data[23:17] == 7'h0C && !o_Init_Done) early_cnt <= early_cnt + 1;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 1;
            if (r_cnt == 1) r_busy <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic va, input logic [15:0] a, input logic vb, input logic [15:0] b);
        valid_a = va;
        sample_a = a;
        valid_b = vb;
        sample_b = b;
        tick();
        valid_a = 1'b0;
        valid_b = 1'b0;
    endtask

    task automatic wait_words(input int n, input string tag);
        int t = 0;
        while (q_log.size() < n && t < 3000) begin
            tick();
            t++;
        end
        while (!(w_ready && !o_DAC_Send) && t < 3000) begin
            tick();
            t++;
        end
        tick();
        tick();
        check(tag, q_log.size(), n);
    endtask

    initial begin
        int b;
        int o0;
        int t;
        repeat (3) tick();
        check("rst_send", {31'd0, o_DAC_Send}, 0);
        check("rst_data", {8'd0, o_DAC_Data}, 0);
        check("rst_overrun", {31'd0, o_Overrun}, 0);
        check("rst_init_done", {31'd0, o_Init_Done}, (N_INIT == 0) ? 1 : 0);
        rst_n = 1'b1;
        wait_words(N_INIT, "init_count");
`ifdef DAC_INIT_SEQ_EN
        check("init_w0", {8'd0, q_log[0]}, 32'h280001);
        check("init_w1", {8'd0, q_log[1]}, 32'h380001);
`endif
        check("init_done", {31'd0, o_Init_Done}, 1);

        b = q_log.size();
        strobe(1, 16'h1234, 1, 16'hFEDC);
        wait_words(b + 2, "rr1_count");
        strobe(1, 16'h8000, 1, 16'h0001);
        wait_words(b + 4, "rr2_count");
        check("rr_w0_A", {8'd0, q_log[b]}, 32'h189234);
        check("rr_w1_B", {8'd0, q_log[b + 1]}, 32'h197EDC);
        check("rr_w2_A", {8'd0, q_log[b + 2]}, 32'h180000);
        check("rr_w3_B", {8'd0, q_log[b + 3]}, 32'h198001);

        b = q_log.size();
        strobe(1, 16'h0000, 0, 16'h0000);
        check("lat_send_early", {31'd0, o_DAC_Send}, 0);
        tick();
        check("lat_send_rise", {31'd0, o_DAC_Send}, 1);
        check("lat_data", {8'd0, o_DAC_Data}, 32'h188000);
        wait_words(b + 1, "a_count");
        check("a_word", {8'd0, q_log[b]}, 32'h188000);

        b = q_log.size();
        strobe(0, 16'h0000, 1, 16'h7FFF);
        wait_words(b + 1, "b_count");
        check("b_word", {8'd0, q_log[b]}, 32'h19FFFF);

        b = q_log.size();
        o0 = ovr_cnt;
        strobe(0, 16'h0000, 1, 16'h0100);
        t = 0;
        while (w_ready && t < 20) begin
            tick();
            t++;
        end
        check("ovr_busy", {31'd0, w_ready}, 0);
        strobe(1, 16'h1111, 0, 16'h0000);
        strobe(1, 16'h2222, 0, 16'h0000);
        wait_words(b + 2, "ovr_count");
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_w0_B", {8'd0, q_log[b]}, 32'h198100);
        check("ovr_w1_A", {8'd0, q_log[b + 1]}, 32'h18A222);

        b = q_log.size();
        o0 = ovr_cnt;
        strobe(1, 16'h0003, 0, 16'h0000);
        strobe(1, 16'hFFFD, 0, 16'h0000);
        wait_words(b + 2, "cons_count");
        check("cons_no_ovr", ovr_cnt - o0, 0);
        check("cons_w0", {8'd0, q_log[b]}, 32'h188003);
        check("cons_w1", {8'd0, q_log[b + 1]}, 32'h187FFD);

        strobe(1, 16'h4000, 1, 16'h4000);
        t = 0;
        while (!o_DAC_Send && t < 100) begin
            tick();
            t++;
        end
        check("mid_send_seen", {31'd0, o_DAC_Send}, 1);
        rst_n = 1'b0;
        tick();
        check("mid_send_drop", {31'd0, o_DAC_Send}, 0);
        tick();
        b = q_log.size();
        rst_n = 1'b1;
        repeat (300) tick();
        check("mid_words", q_log.size() - b, N_INIT);
`ifdef DAC_INIT_SEQ_EN
        check("mid_init_w0", {8'd0, q_log[b]}, 32'h280001);
        check("mid_init_w1", {8'd0, q_log[b + 1]}, 32'h380001);
`endif
        check("mid_init_done", {31'd0, o_Init_Done}, 1);
        check("early_words", early_cnt, 0);
        check("data_stable", unstable_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
